// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a single-port data bus
// with wait states, byte-lane steering, load extension and exception reporting.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] addr,
  input  logic [1:0]  save,
  input  logic [2:0]  load,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  exc_code,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  ld_q, ld_d;       // latched load kind; 000 for stores so rdata reads 0
  logic [1:0]  alo_q, alo_d;

  logic        is_st, legal_ld, op, mis, sz_word, sz_half;
  logic [3:0]  be_c;
  logic [31:0] wd_c, ext_c;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Decode the presented request: size, alignment, byte enables, store lanes.
  always_comb begin
    is_st    = (save != 2'b00);
    legal_ld = (load == 3'b011) || (load == 3'b010) || (load == 3'b001) ||
               (load == 3'b110) || (load == 3'b101);
    op       = req_valid && (is_st || legal_ld);
    sz_word  = is_st ? (save == 2'b11) : (load[1:0] == 2'b11);
    sz_half  = is_st ? (save == 2'b10) : (load[1:0] == 2'b10);
    mis      = (sz_half && addr[0]) || (sz_word && (addr[1:0] != 2'b00));
    if (sz_word) begin
      be_c = 4'b1111;
      wd_c = wdata;
    end else if (sz_half) begin
      be_c = addr[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{wdata[15:0]}};
    end else begin
      be_c = 4'b0001 << addr[1:0];
      wd_c = {4{wdata[7:0]}};
    end
  end

  // Select and sign/zero-extend the loaded lane from the bus read word.
  always_comb begin
    half_sel = alo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (alo_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (ld_q)
      3'b011:  ext_c = bus_rdata;
      3'b010:  ext_c = {{16{half_sel[15]}}, half_sel};
      3'b110:  ext_c = {16'h0000, half_sel};
      3'b001:  ext_c = {{24{byte_sel[7]}}, byte_sel};
      3'b101:  ext_c = {24'h000000, byte_sel};
      default: ext_c = 32'h0000_0000;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    exc_d       = exc_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_d        = ld_q;
    alo_d       = alo_q;
    unique case (state_q)
      IDLE: begin
        if (op) begin
          if (mis) begin
            exc_d   = is_st ? 2'b10 : 2'b01;
            rdata_d = 32'h0000_0000;
            done_d  = 1'b1;
            state_d = ERR;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = is_st;
            bus_be_d    = be_c;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = wd_c;
            ld_d        = is_st ? 3'b000 : load;
            alo_d       = addr[1:0];
            cnt_d       = '0;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        if (bus_ack || (cnt_q == CNT_MAX)) begin
          rdata_d   = bus_ack ? ext_c : 32'h0000_0000;
          exc_d     = bus_ack ? 2'b00 : 2'b11;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_be_d  = 4'b0000;
          state_d   = bus_ack ? DONE : ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset also aborts any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      exc_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      ld_q        <= 3'b000;
      alo_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_q        <= ld_d;
      alo_q       <= alo_d;
    end
  end

  // Stall is combinational so the MEM stage freezes in the accept cycle itself.
  assign stall     = !reset && (((state_q == IDLE) && op) || (state_q == BUS));
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign exc_code  = exc_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 4).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr;
  logic [1:0]  save;
  logic [2:0]  load;
  logic [31:0] wdata;
  logic        stall, done, bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  exc_code;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;

  int          obs_done_cyc, obs_req_cycles, obs_unstable;
  logic [31:0] obs_stall_mask, obs_rdata, obs_addr, obs_wdata;
  logic [1:0]  obs_exc;
  logic [3:0]  obs_be;
  logic        obs_we;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .addr(addr), .save(save),
    .load(load), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .exc_code(exc_code), .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access starting just after a rising edge; acks on BUS cycle index `waits`.
  task automatic run_op(input logic [1:0] sv, input logic [2:0] ld, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] brd);
    obs_done_cyc = -1; obs_req_cycles = 0; obs_unstable = 0; obs_stall_mask = '0;
    obs_rdata = 'x; obs_exc = 'x; obs_addr = 'x; obs_wdata = 'x; obs_be = 'x; obs_we = 'x;
    req_valid = 1'b1; save = sv; load = ld; addr = a; wdata = wd; bus_rdata = brd;
    bus_ack = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (stall && cyc < 32) obs_stall_mask[cyc] = 1'b1;
      if (bus_req) begin
        if (obs_req_cycles == 0) begin
          obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be; obs_we = bus_we;
        end else if (bus_addr !== obs_addr || bus_wdata !== obs_wdata ||
                     bus_be !== obs_be || bus_we !== obs_we) begin
          obs_unstable++;
        end
        obs_req_cycles++;
        bus_ack = ((obs_req_cycles - 1) == waits);
      end else begin
        bus_ack = 1'b0;
      end
      if (done) begin
        obs_done_cyc = cyc; obs_rdata = rdata; obs_exc = exc_code;
        req_valid = 1'b0; save = 2'b00; load = 3'b000;
        break;
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    req_valid = 1'b0;
    if (obs_done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("done_pulse_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; addr = '0; save = '0; load = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_exc", 32'(exc_code), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // lb 0x1003: byte 3 = 0x80, sign-extended
    run_op(2'b00, 3'b001, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    check("lb_done_cyc", 32'(obs_done_cyc), 32'd2);
    check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    check("lb_exc", 32'(obs_exc), 32'd0);
    check("lb_be", 32'(obs_be), 32'b1000);
    check("lb_we", 32'(obs_we), 32'd0);
    check("lb_addr", obs_addr, 32'h0000_1000);
    check("lb_stall", obs_stall_mask, 32'b011);

    // lhu 0x2002 with 3 wait cycles: ack lands on the last legal BUS cycle
    run_op(2'b00, 3'b110, 32'h0000_2002, 32'h0, 3, 32'hBEEF_0001);
    check("lhu_done_cyc", 32'(obs_done_cyc), 32'd5);
    check("lhu_rdata", obs_rdata, 32'h0000_BEEF);
    check("lhu_exc", 32'(obs_exc), 32'd0);
    check("lhu_stall", obs_stall_mask, 32'h1F);
    check("lhu_req_cycles", 32'(obs_req_cycles), 32'd4);
    check("lhu_bus_stable", 32'(obs_unstable), 32'd0);
    check("lhu_be", 32'(obs_be), 32'b1100);

    // sb 0x0001
    run_op(2'b01, 3'b000, 32'h0000_0001, 32'h0000_00A5, 0, 32'hFFFF_FFFF);
    check("sb_addr", obs_addr, 32'h0000_0000);
    check("sb_be", 32'(obs_be), 32'b0010);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    check("sb_we", 32'(obs_we), 32'd1);
    check("sb_rdata", obs_rdata, 32'd0);
    check("sb_done_cyc", 32'(obs_done_cyc), 32'd2);

    // sh + lw both present: store wins, load ignored
    run_op(2'b10, 3'b011, 32'h0000_0102, 32'h1234_CAFE, 1, 32'h5555_5555);
    check("sh_be", 32'(obs_be), 32'b1100);
    check("sh_wdata", obs_wdata, 32'hCAFE_CAFE);
    check("sh_we", 32'(obs_we), 32'd1);
    check("sh_rdata", obs_rdata, 32'd0);
    check("sh_done_cyc", 32'(obs_done_cyc), 32'd3);

    // sw 0x0006 misaligned
    run_op(2'b11, 3'b000, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'h0);
    check("sw_mis_req", 32'(obs_req_cycles), 32'd0);
    check("sw_mis_done_cyc", 32'(obs_done_cyc), 32'd1);
    check("sw_mis_exc", 32'(obs_exc), 32'b10);
    check("sw_mis_stall", obs_stall_mask, 32'b1);

    // lh 0x0003 misaligned
    run_op(2'b00, 3'b010, 32'h0000_0003, 32'h0, 0, 32'h0);
    check("lh_mis_exc", 32'(obs_exc), 32'b01);
    check("lh_mis_done_cyc", 32'(obs_done_cyc), 32'd1);

    // Other load lanes and kinds
    run_op(2'b00, 3'b001, 32'h0000_1002, 32'h0, 0, 32'h80FF_1234);
    check("lb2_rdata", obs_rdata, 32'hFFFF_FFFF);
    run_op(2'b00, 3'b101, 32'h0000_1001, 32'h0, 0, 32'h80FF_1234);
    check("lbu1_rdata", obs_rdata, 32'h0000_0012);
    run_op(2'b00, 3'b010, 32'h0000_1000, 32'h0, 0, 32'h80FF_1234);
    check("lh0_rdata", obs_rdata, 32'h0000_1234);
    run_op(2'b00, 3'b010, 32'h0000_1002, 32'h0, 2, 32'h80FF_1234);
    check("lh2_rdata", obs_rdata, 32'hFFFF_80FF);
    run_op(2'b00, 3'b011, 32'h0000_100C, 32'h0, 0, 32'h80FF_1234);
    check("lw_rdata", obs_rdata, 32'h80FF_1234);
    check("lw_be", 32'(obs_be), 32'hF);

    // Timeout: ack never arrives
    run_op(2'b00, 3'b011, 32'h0000_3000, 32'h0, 100, 32'h1111_1111);
    check("to_req_cycles", 32'(obs_req_cycles), 32'd4);
    check("to_exc", 32'(obs_exc), 32'b11);
    check("to_rdata", obs_rdata, 32'd0);
    check("to_done_cyc", 32'(obs_done_cyc), 32'd5);

    // Stray ack while idle does nothing
    bus_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stray_ack_req", 32'(bus_req), 32'd0);
    check("stray_ack_done2", 32'(done), 32'd0);
    bus_ack = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of BUS aborts immediately
    req_valid = 1'b1; save = 2'b00; load = 3'b011; addr = 32'h0000_0040; bus_rdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_bus_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    req_valid = 1'b0; load = 3'b000;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", 32'(done), 32'd0);
    run_op(2'b00, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h1234_5678);
    check("post_rst_done_cyc", 32'(obs_done_cyc), 32'd2);
    check("post_rst_rdata", obs_rdata, 32'h1234_5678);
    check("post_rst_exc", 32'(obs_exc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
